// File: rtl/ast_packet_filter.sv
// Avalon-ST packet filter: stores each packet whole and forwards it only if its eop tag equals PASS_CHANNEL.
// Define PACKET_FILTER_STATS_EN to add pass/drop counters and a sticky overflow flag.
module ast_packet_filter #(
  parameter int DWIDTH        = 64,
  parameter int EMPTY_WIDTH   = 3,
  parameter int CHANNEL_WIDTH = 1,
  parameter int PASS_CHANNEL  = 1,
  parameter int BUF_AWIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DWIDTH-1:0]        ast_data_i,
  input  logic                     ast_valid_i,
  input  logic                     ast_startofpacket_i,
  input  logic                     ast_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
  output logic                     ast_ready_o,
  output logic [DWIDTH-1:0]        ast_data_o,
  output logic                     ast_startofpacket_o,
  output logic                     ast_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   ast_empty_o,
  output logic                     ast_valid_o,
  input  logic                     ast_ready_i
`ifdef PACKET_FILTER_STATS_EN
  ,
  output logic [31:0]              pass_cnt_o,
  output logic [31:0]              drop_cnt_o,
  output logic                     ovf_o
`endif
);

  localparam int WW = DWIDTH + EMPTY_WIDTH + 2;
  localparam int PW = BUF_AWIDTH + 1;
  localparam logic [CHANNEL_WIDTH-1:0] PASS_TAG = CHANNEL_WIDTH'(PASS_CHANNEL);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]   commit_ptr, commit_ptr_nxt;
  logic [PW-1:0]   commit_rd;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_base;
  logic [WW-1:0]   mem [2**BUF_AWIDTH];
  logic [WW-1:0]   wr_word;
  logic            wr_en, full, ovf, accept, tag_pass, rd_issue;

  assign full = (wr_ptr[BUF_AWIDTH] != rd_ptr[BUF_AWIDTH]) &&
                (wr_ptr[BUF_AWIDTH-1:0] == rd_ptr[BUF_AWIDTH-1:0]);
  // Overflow only matters when nothing committed can drain to make room.
  assign ovf         = (state == WRITE) && full && (rd_ptr == commit_ptr);
  assign ast_ready_o = ~rst_i & ((state == DROP) | ~full);
  assign accept      = ast_valid_i & ast_ready_o;
  assign tag_pass    = (ast_channel_i == PASS_TAG);
  assign wr_word     = {ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_empty_i};

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    wr_en          = 1'b0;
    // A sop arriving mid-packet restarts the packet over the aborted one.
    wr_base        = (state == WRITE && ast_startofpacket_i) ? commit_ptr : wr_ptr;
    case (state)
      IDLE, WRITE: begin
        if (ovf) begin
          wr_ptr_nxt = commit_ptr;
          state_nxt  = DROP;
        end else if (accept && (state == WRITE || ast_startofpacket_i)) begin
          if (ast_endofpacket_i) begin
            state_nxt = IDLE;
            if (tag_pass) begin
              wr_en          = 1'b1;
              wr_ptr_nxt     = wr_base + 1'b1;
              commit_ptr_nxt = wr_base + 1'b1;
            end else begin
              wr_ptr_nxt = commit_ptr;
            end
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_base + 1'b1;
            state_nxt  = WRITE;
          end
        end
      end
      DROP: begin
        if (accept && ast_endofpacket_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_base[BUF_AWIDTH-1:0]] <= wr_word;
  end

  // The read side sees commits one cycle late, so a word is never read in its write cycle.
  assign rd_issue = (rd_ptr != commit_rd) && (!ast_valid_o || ast_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_rd           <= '0;
      rd_ptr              <= '0;
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
    end else begin
      commit_rd <= commit_ptr;
      if (rd_issue) begin
        {ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o} <= mem[rd_ptr[BUF_AWIDTH-1:0]];
        ast_valid_o <= 1'b1;
        rd_ptr      <= rd_ptr + 1'b1;
      end else if (ast_ready_i) begin
        ast_valid_o <= 1'b0;
      end
    end
  end

`ifdef PACKET_FILTER_STATS_EN
  logic commit_ev, abort_ev, reject_ev;

  assign commit_ev = (commit_ptr_nxt != commit_ptr);
  assign abort_ev  = (state == WRITE) && !ovf && accept && ast_startofpacket_i;
  assign reject_ev = !ovf && accept && ast_endofpacket_i && !tag_pass &&
                     ((state == WRITE) || (state == IDLE && ast_startofpacket_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_cnt_o <= '0;
      drop_cnt_o <= '0;
      ovf_o      <= 1'b0;
    end else begin
      pass_cnt_o <= pass_cnt_o + 32'(commit_ev);
      drop_cnt_o <= drop_cnt_o + 32'(abort_ev) + 32'(reject_ev) + 32'(ovf);
      if (ovf) ovf_o <= 1'b1;
    end
  end
`endif

endmodule
